// File: rtl/csa_accum.sv
// Streaming 4-operand accumulator: two 4:2 carry-save levels per beat, one carry-propagate add per frame.
// Optional macro CSA_ACCUM_PIPE_EN registers stage A before stage B (adds a DRAIN cycle per frame).
module csa_accum #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 40,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic [CW-1:0] out_count
);

    typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_SUM, ST_OUT} state_e;

    // Bitwise 4:2 compressor; returns {carry already shifted to weight 1, sum}.
    function automatic logic [2*AW-1:0] csa42(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic [AW-1:0] c, input logic [AW-1:0] d);
        logic [AW-1:0] s;
        logic [AW-1:0] cy;
        logic          ci;
        logic          co;
        logic          t;
        ci = 1'b0;
        for (int i = 0; i < int'(AW); i++) begin
            t     = a[i] ^ b[i] ^ c[i];
            co    = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
            s[i]  = t ^ d[i] ^ ci;
            cy[i] = (t & d[i]) | (t & ci) | (d[i] & ci);
            ci    = co;
        end
        return {AW'(cy << 1), s};
    endfunction

    state_e        state_q;
    logic [AW-1:0] acc_s_q, acc_c_q, acc_s_d, acc_c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] out_data_q;
    logic [CW-1:0] out_count_q;
    logic          out_valid_q;

    logic          accept;
    logic          out_hs;
    logic [AW-1:0] sa, ca, sb, cb;
    logic [AW-1:0] b_s, b_c;
    logic          b_en;

    assign in_ready  = (state_q == ST_ACC);
    assign accept    = in_valid & in_ready;
    assign out_hs    = (state_q == ST_OUT) & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    assign {ca, sa} = csa42(AW'(in0), AW'(in1), AW'(in2), AW'(in3));
    assign {cb, sb} = csa42(b_s, b_c, acc_s_q, acc_c_q);

`ifdef CSA_ACCUM_PIPE_EN
    logic [AW-1:0] pipe_s_q, pipe_c_q;
    logic          pipe_v_q;
    localparam state_e LAST_NEXT = ST_DRAIN;

    // Stage A result held one cycle; stage B absorbs it while the next beat is compressed.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pipe_s_q <= '0;
            pipe_c_q <= '0;
            pipe_v_q <= 1'b0;
        end else if (out_hs) begin
            pipe_s_q <= '0;
            pipe_c_q <= '0;
            pipe_v_q <= 1'b0;
        end else begin
            pipe_v_q <= accept;
            if (accept) begin
                pipe_s_q <= sa;
                pipe_c_q <= ca;
            end
        end
    end

    assign b_s  = pipe_s_q;
    assign b_c  = pipe_c_q;
    assign b_en = pipe_v_q;
`else
    localparam state_e LAST_NEXT = ST_SUM;

    assign b_s  = sa;
    assign b_c  = ca;
    assign b_en = accept;
`endif

    always_comb begin
        acc_s_d = acc_s_q;
        acc_c_d = acc_c_q;
        cnt_d   = cnt_q;
        if (b_en) begin
            acc_s_d = sb;
            acc_c_d = cb;
        end
        if (accept && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (out_hs) begin
            acc_s_d = '0;
            acc_c_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_ACC;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_s_q <= acc_s_d;
            acc_c_q <= acc_c_d;
            cnt_q   <= cnt_d;
            case (state_q)
                ST_ACC: begin
                    if (accept && in_last) state_q <= LAST_NEXT;
                end
                ST_DRAIN: state_q <= ST_SUM;
                ST_SUM: begin
                    out_data_q  <= acc_s_q + acc_c_q;
                    out_count_q <= cnt_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum: two instances (AW=16/CW=16 and AW=10/CW=2) share stimulus; integer model feeds a scoreboard.
module tb_csa_accum;

`ifdef CSA_ACCUM_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic        in_valid, in_last, out_ready;
    logic [7:0]  in0, in1, in2, in3;
    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [15:0] a_out_data, a_out_count;
    logic [9:0]  b_out_data;
    logic [1:0]  b_out_count;

    typedef struct {
        logic [15:0] da;
        logic [15:0] ca;
        logic [9:0]  db;
        logic [1:0]  cb;
    } exp_t;

    exp_t            exp_q[$];
    longint unsigned m_sum;
    int unsigned     m_cnt;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    csa_accum #(.DW(8), .AW(16), .CW(16)) u_dut_a (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_count(a_out_count)
    );

    csa_accum #(.DW(8), .AW(10), .CW(2)) u_dut_b (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_count(b_out_count)
    );

    task automatic model_clear();
        m_sum = 0;
        m_cnt = 0;
    endtask

    // Presents one beat, holds it until accepted, then updates the model.
    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic last);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        in0 = a; in1 = b; in2 = c; in3 = d; in_last = last; in_valid = 1'b1;
        while (!a_in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!a_in_ready) begin
            checks++; errors++;
            $display("FAIL send_beat_timeout: in_ready=%0b required 1", a_in_ready);
        end else begin
            m_sum += longint'(a) + longint'(b) + longint'(c) + longint'(d);
            m_cnt++;
            if (last) begin
                e.da = 16'(m_sum);
                e.ca = (m_cnt > 65535) ? 16'hffff : 16'(m_cnt);
                e.db = 10'(m_sum);
                e.cb = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
                exp_q.push_back(e);
                model_clear();
            end
            @(posedge clk);
        end
    endtask

    // Drops in_valid and counts edges until out_valid is seen (bounded).
    task automatic wait_out(output int edges);
        edges = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (!a_out_valid && edges < 100) begin
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid: got %0b exp 0", a_out_valid); end
        checks++; if (a_out_data !== 16'd0) begin errors++; $display("FAIL rst_a_data: got %0d exp 0", a_out_data); end
        checks++; if (a_out_count !== 16'd0) begin errors++; $display("FAIL rst_a_count: got %0d exp 0", a_out_count); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready: got %0b exp 1", a_in_ready); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %0b exp 0", b_out_valid); end
        checks++; if (b_out_data !== 10'd0) begin errors++; $display("FAIL rst_b_data: got %0d exp 0", b_out_data); end
        checks++; if (b_out_count !== 2'd0) begin errors++; $display("FAIL rst_b_count: got %0d exp 0", b_out_count); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready: got %0b exp 1", b_in_ready); end
        nreset = 1'b1;
    endtask

    task automatic test_basic();
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        send_beat(8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        send_beat(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d exp %0d", lat, LAT); end
        checks++; if (a_out_data !== e.da) begin errors++; $display("FAIL basic_a_data: got %0d exp %0d", a_out_data, e.da); end
        checks++; if (a_out_count !== e.ca) begin errors++; $display("FAIL basic_a_count: got %0d exp %0d", a_out_count, e.ca); end
        checks++; if (b_out_data !== e.db) begin errors++; $display("FAIL basic_b_data: got %0d exp %0d", b_out_data, e.db); end
        checks++; if (b_out_count !== e.cb) begin errors++; $display("FAIL basic_b_count: got %0d exp %0d", b_out_count, e.cb); end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b exp 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %0b exp 1", a_in_ready); end
    endtask

    task automatic test_single();
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        send_beat(8'd0, 8'd0, 8'd0, 8'd7, 1'b1);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b exp 1", a_out_valid); end
        checks++; if (a_out_data !== e.da) begin errors++; $display("FAIL single_a_data: got %0d exp %0d", a_out_data, e.da); end
        checks++; if (a_out_count !== e.ca) begin errors++; $display("FAIL single_a_count: got %0d exp %0d", a_out_count, e.ca); end
        checks++; if (b_out_data !== e.db) begin errors++; $display("FAIL single_b_data: got %0d exp %0d", b_out_data, e.db); end
        checks++; if (b_out_count !== e.cb) begin errors++; $display("FAIL single_b_count: got %0d exp %0d", b_out_count, e.cb); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(8'd255, 8'd255, 8'd255, 8'd255, i == 3);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++; if (a_out_data !== e.da) begin errors++; $display("FAIL wrap_a_data: got %0d exp %0d", a_out_data, e.da); end
        checks++; if (a_out_count !== e.ca) begin errors++; $display("FAIL wrap_a_count: got %0d exp %0d", a_out_count, e.ca); end
        checks++; if (b_out_data !== e.db) begin errors++; $display("FAIL wrap_b_data: got %0d exp %0d", b_out_data, e.db); end
        checks++; if (b_out_count !== e.cb) begin errors++; $display("FAIL wrap_b_count: got %0d exp %0d", b_out_count, e.cb); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), i == 4);
        wait_out(lat);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b exp 1", i, a_out_valid); end
            checks++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b/%0b exp 0", i, a_in_ready, b_in_ready); end
            checks++; if (a_out_data !== e.da) begin errors++; $display("FAIL bp_a_data[%0d]: got %0d exp %0d", i, a_out_data, e.da); end
            checks++; if (a_out_count !== e.ca) begin errors++; $display("FAIL bp_a_count[%0d]: got %0d exp %0d", i, a_out_count, e.ca); end
            checks++; if (b_out_data !== e.db) begin errors++; $display("FAIL bp_b_data[%0d]: got %0d exp %0d", i, b_out_data, e.db); end
            checks++; if (b_out_count !== e.cb) begin errors++; $display("FAIL bp_b_count[%0d]: got %0d exp %0d", i, b_out_count, e.cb); end
            in0 = 8'($urandom); in1 = 8'($urandom); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %0b exp 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %0b exp 1", a_in_ready); end
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_one_hs: got %0b exp 0", a_out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(8'd10, 8'd10, 8'd10, 8'd10, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        nreset   = 1'b0;
        model_clear();
        #1;
        checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b/%0b exp 0", a_out_valid, b_out_valid); end
        checks++; if (a_out_data !== 16'd0 || a_out_count !== 16'd0) begin errors++; $display("FAIL midrst_a_out: got %0d/%0d exp 0", a_out_data, a_out_count); end
        checks++; if (b_out_data !== 10'd0 || b_out_count !== 2'd0) begin errors++; $display("FAIL midrst_b_out: got %0d/%0d exp 0", b_out_data, b_out_count); end
        checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b/%0b exp 1", a_in_ready, b_in_ready); end
        @(negedge clk);
        nreset = 1'b1;
        send_beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++; if (a_out_data !== e.da) begin errors++; $display("FAIL midrst_a_data: got %0d exp %0d", a_out_data, e.da); end
        checks++; if (a_out_count !== e.ca) begin errors++; $display("FAIL midrst_a_count: got %0d exp %0d", a_out_count, e.ca); end
        checks++; if (b_out_data !== e.db) begin errors++; $display("FAIL midrst_b_data: got %0d exp %0d", b_out_data, e.db); end
        @(negedge clk);
        // Reset while a result is waiting discards it without a handshake.
        out_ready = 1'b0;
        send_beat(8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
        wait_out(lat);
        void'(exp_q.pop_front());
        nreset = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL outrst_valid: got %0b exp 0", a_out_valid); end
        @(negedge clk);
        nreset    = 1'b1;
        out_ready = 1'b1;
        send_beat(8'd2, 8'd0, 8'd0, 8'd0, 1'b1);
        wait_out(lat);
        e = exp_q.pop_front();
        checks++; if (a_out_data !== e.da) begin errors++; $display("FAIL outrst_a_data: got %0d exp %0d", a_out_data, e.da); end
        checks++; if (a_out_count !== e.ca) begin errors++; $display("FAIL outrst_a_count: got %0d exp %0d", a_out_count, e.ca); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        localparam int NFR = 24;
        int got;
        int cyc;
        fork
            begin
                for (int f = 0; f < NFR; f++) begin
                    int nb;
                    nb = int'($urandom_range(1, 6));
                    for (int b = 0; b < nb; b++)
                        send_beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), b == nb - 1);
                end
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            begin
                exp_t e;
                logic rdy;
                got = 0;
                cyc = 0;
                while (got < NFR && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    rdy       = ($urandom_range(0, 3) != 0);
                    out_ready = rdy;
                    if (a_out_valid && rdy) begin
                        got++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL b2b_unexpected: got output with data %0d exp none", a_out_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (a_out_data !== e.da || a_out_count !== e.ca || b_out_data !== e.db || b_out_count !== e.cb) begin
                                errors++;
                                $display("FAIL b2b_frame[%0d]: got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", got, a_out_data,
                                         a_out_count, b_out_data, b_out_count, e.da, e.ca, e.db, e.cb);
                            end
                        end
                    end
                end
                checks++;
                if (got < NFR) begin errors++; $display("FAIL b2b_timeout: got %0d frames exp %0d", got, NFR); end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d pending exp 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
